// File: rtl/accel_wb_ctrl.sv
// -----------------------------------------------------------------------------
// accel_wb_ctrl
//   Issues FFT/crypto commands from decode to an external accelerator over a
//   valid/ready request channel, collects the response, and owns the register
//   file write port. ALU writebacks always win the port; an accelerator result
//   waits in WRITE until the port is free. The pipeline is stalled from the
//   dispatch-accept cycle until the accelerator result has been written or the
//   op has been aborted on timeout.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   dispatch_valid           decode presents an instruction this cycle
//   fft, crypto, opcode      decoded op class flags and raw opcode
//   rd, rs1_data, rs2_data   destination register and operands
//   alu_valid/alu_rd/alu_data  ALU writeback request
//   acc_req_valid/ready      request handshake; acc_op/acc_a/acc_b payload
//   acc_rsp_valid/ready      response handshake; acc_rsp_data payload
//   stall                    freeze fetch/decode
//   reg_write/wb_rd/wb_data  registered regfile write port (1-cycle latency)
//   acc_error                one-cycle pulse when a WAIT times out
// -----------------------------------------------------------------------------
module accel_wb_ctrl #(
  parameter int DATA_W  = 19,
  parameter int REG_AW  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dispatch_valid,
  input  logic              fft,
  input  logic              crypto,
  input  logic [4:0]        opcode,
  input  logic [REG_AW-1:0] rd,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              acc_req_valid,
  input  logic              acc_req_ready,
  output logic [4:0]        acc_op,
  output logic [DATA_W-1:0] acc_a,
  output logic [DATA_W-1:0] acc_b,
  input  logic              acc_rsp_valid,
  input  logic [DATA_W-1:0] acc_rsp_data,
  output logic              acc_rsp_ready,
  output logic              stall,
  output logic              reg_write,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              acc_error
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t state_r, state_nxt_s;

  logic [4:0]        op_r;
  logic [REG_AW-1:0] rd_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic [TW-1:0]     timer_r;

  logic              accept_s;
  logic              rsp_take_s;
  logic              timer_clr_s;
  logic              timer_inc_s;
  logic              err_s;
  logic              acc_wb_s;
  logic              stall_s;
  logic              req_valid_s;
  logic              rsp_ready_s;

  logic              we_s;
  logic [REG_AW-1:0] wrd_s;
  logic [DATA_W-1:0] wdata_s;

  logic              reg_write_r;
  logic [REG_AW-1:0] wb_rd_r;
  logic [DATA_W-1:0] wb_data_r;
  logic              acc_error_r;

  // Next-state and control decode for the accelerator sequencer.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    rsp_take_s  = 1'b0;
    timer_clr_s = 1'b0;
    timer_inc_s = 1'b0;
    err_s       = 1'b0;
    acc_wb_s    = 1'b0;
    stall_s     = 1'b0;
    req_valid_s = 1'b0;
    rsp_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        // Stall rises in the accept cycle itself so decode holds the next op.
        if (dispatch_valid && (fft || crypto)) begin
          accept_s    = 1'b1;
          stall_s     = 1'b1;
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        stall_s     = 1'b1;
        req_valid_s = 1'b1;
        if (acc_req_ready) begin
          timer_clr_s = 1'b1;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT: begin
        stall_s     = 1'b1;
        rsp_ready_s = 1'b1;
        // A response arriving on the last timeout cycle is still taken.
        if (acc_rsp_valid) begin
          rsp_take_s  = 1'b1;
          state_nxt_s = WRITE;
        end else if (timer_r == TIMEOUT_V) begin
          err_s       = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          timer_inc_s = 1'b1;
          state_nxt_s = WAIT;
        end
      end
      WRITE: begin
        stall_s = 1'b1;
        // The ALU owns the port this cycle; retry the accelerator write next cycle.
        if (alu_valid) begin
          state_nxt_s = WRITE;
        end else begin
          acc_wb_s    = 1'b1;
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Writeback source select: ALU first, then a pending accelerator result.
  always_comb begin
    we_s    = 1'b0;
    wrd_s   = {REG_AW{1'b0}};
    wdata_s = {DATA_W{1'b0}};
    if (alu_valid) begin
      we_s    = 1'b1;
      wrd_s   = alu_rd;
      wdata_s = alu_data;
    end else if (acc_wb_s) begin
      we_s    = 1'b1;
      wrd_s   = rd_r;
      wdata_s = rsp_data_r;
    end else begin
      we_s    = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture opcode, destination and operands at dispatch accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r <= 5'd0;
      rd_r <= {REG_AW{1'b0}};
      a_r  <= {DATA_W{1'b0}};
      b_r  <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      op_r <= opcode;
      rd_r <= rd;
      a_r  <= rs1_data;
      b_r  <= rs2_data;
    end
  end

  // WAIT-state timeout counter, cleared on request handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_r <= {TW{1'b0}};
    end else if (timer_clr_s) begin
      timer_r <= {TW{1'b0}};
    end else if (timer_inc_s) begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // Hold the accelerator result until the write port is won.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data_r <= {DATA_W{1'b0}};
    end else if (rsp_take_s) begin
      rsp_data_r <= acc_rsp_data;
    end
  end

  // Registered writeback port and timeout error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_r <= 1'b0;
      wb_rd_r     <= {REG_AW{1'b0}};
      wb_data_r   <= {DATA_W{1'b0}};
      acc_error_r <= 1'b0;
    end else begin
      reg_write_r <= we_s;
      wb_rd_r     <= wrd_s;
      wb_data_r   <= wdata_s;
      acc_error_r <= err_s;
    end
  end

  assign acc_req_valid = req_valid_s;
  assign acc_rsp_ready = rsp_ready_s;
  assign stall         = stall_s;
  assign acc_op        = op_r;
  assign acc_a         = a_r;
  assign acc_b         = b_r;
  assign reg_write     = reg_write_r;
  assign wb_rd         = wb_rd_r;
  assign wb_data       = wb_data_r;
  assign acc_error     = acc_error_r;

endmodule

// File: tb/tb_accel_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_accel_wb_ctrl
//   Directed bench for accel_wb_ctrl (TIMEOUT reduced to 8). Inputs change 1 ns
//   after a rising edge; outputs are checked 1-2 ns after the edge.
// -----------------------------------------------------------------------------
module tb_accel_wb_ctrl;

  localparam int DATA_W = 19;
  localparam int REG_AW = 3;

  logic              clk;
  logic              rst;
  logic              dispatch_valid;
  logic              fft;
  logic              crypto;
  logic [4:0]        opcode;
  logic [REG_AW-1:0] rd;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              acc_req_valid;
  logic              acc_req_ready;
  logic [4:0]        acc_op;
  logic [DATA_W-1:0] acc_a;
  logic [DATA_W-1:0] acc_b;
  logic              acc_rsp_valid;
  logic [DATA_W-1:0] acc_rsp_data;
  logic              acc_rsp_ready;
  logic              stall;
  logic              reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              acc_error;

  int checks;
  int failures;

  accel_wb_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .fft(fft), .crypto(crypto), .opcode(opcode),
    .rd(rd), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .acc_req_valid(acc_req_valid), .acc_req_ready(acc_req_ready),
    .acc_op(acc_op), .acc_a(acc_a), .acc_b(acc_b),
    .acc_rsp_valid(acc_rsp_valid), .acc_rsp_data(acc_rsp_data),
    .acc_rsp_ready(acc_rsp_ready), .stall(stall),
    .reg_write(reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .acc_error(acc_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic f, input logic c, input logic [4:0] op,
                          input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b);
    dispatch_valid = 1'b1;
    fft            = f;
    crypto         = c;
    opcode         = op;
    rd             = r;
    rs1_data       = a;
    rs2_data       = b;
  endtask

  task automatic undispatch();
    dispatch_valid = 1'b0;
    fft            = 1'b0;
    crypto         = 1'b0;
    opcode         = 5'd0;
    rs1_data       = 19'h7FFFF;
    rs2_data       = 19'h7FFFF;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b0;
    dispatch_valid = 1'b0;
    fft            = 1'b0;
    crypto         = 1'b0;
    opcode         = 5'd0;
    rd             = 3'd0;
    rs1_data       = 19'h0;
    rs2_data       = 19'h0;
    alu_valid      = 1'b0;
    alu_rd         = 3'd0;
    alu_data       = 19'h0;
    acc_req_ready  = 1'b0;
    acc_rsp_valid  = 1'b0;
    acc_rsp_data   = 19'h0;

    // Reset state
    cycle(); cycle();
    check("rst_stall", stall, 0);
    check("rst_req_valid", acc_req_valid, 0);
    check("rst_rsp_ready", acc_rsp_ready, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_acc_op", acc_op, 0);
    check("rst_acc_error", acc_error, 0);
    rst = 1'b1;
    cycle();

    // 1: fft, immediate handshake, response 3 cycles into WAIT
    dispatch(1'b1, 1'b0, 5'b11000, 3'd3, 19'h00012, 19'h00034);
    acc_req_ready = 1'b1;
    #1;
    check("t1_stall_accept", stall, 1);
    check("t1_no_req_yet", acc_req_valid, 0);
    cycle();
    undispatch();
    #1;
    check("t1_req_valid", acc_req_valid, 1);
    check("t1_acc_op", acc_op, 5'b11000);
    check("t1_acc_a", acc_a, 19'h00012);
    check("t1_acc_b", acc_b, 19'h00034);
    cycle();
    acc_req_ready = 1'b0;
    check("t1_wait_rsp_ready", acc_rsp_ready, 1);
    check("t1_wait_req_low", acc_req_valid, 0);
    cycle(); cycle();
    acc_rsp_valid = 1'b1;
    acc_rsp_data  = 19'h1ABCD;
    cycle();
    acc_rsp_valid = 1'b0;
    acc_rsp_data  = 19'h0;
    check("t1_write_stall", stall, 1);
    check("t1_no_early_write", reg_write, 0);
    cycle();
    check("t1_reg_write", reg_write, 1);
    check("t1_wb_rd", wb_rd, 3);
    check("t1_wb_data", wb_data, 19'h1ABCD);
    check("t1_stall_after", stall, 0);
    cycle();
    check("t1_single_write", reg_write, 0);

    // 2: crypto dec, request held 4 cycles with ready low, handshake on the 5th
    dispatch(1'b0, 1'b1, 5'b11010, 3'd2, 19'h0AAAA, 19'h05555);
    acc_req_ready = 1'b0;
    cycle();
    undispatch();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_req_valid", acc_req_valid, 1);
      check("t2_acc_op", acc_op, 5'b11010);
      check("t2_acc_a", acc_a, 19'h0AAAA);
      check("t2_acc_b", acc_b, 19'h05555);
      if (i == 4) acc_req_ready = 1'b1;
      cycle();
    end
    acc_req_ready = 1'b0;
    check("t2_req_dropped", acc_req_valid, 0);
    check("t2_in_wait", acc_rsp_ready, 1);
    acc_rsp_valid = 1'b1;
    acc_rsp_data  = 19'h00F0F;
    cycle();
    acc_rsp_valid = 1'b0;
    cycle();
    check("t2_reg_write", reg_write, 1);
    check("t2_wb_rd", wb_rd, 2);
    check("t2_wb_data", wb_data, 19'h00F0F);

    // 3: timeout (TIMEOUT=8), error 9 cycles after request accept
    dispatch(1'b1, 1'b0, 5'b11000, 3'd4, 19'h00001, 19'h00002);
    acc_req_ready = 1'b1;
    cycle();
    undispatch();
    cycle();
    acc_req_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check("t3_no_early_error", acc_error, 0);
      check("t3_no_write_wait", reg_write, 0);
    end
    cycle();
    check("t3_acc_error", acc_error, 1);
    check("t3_no_write", reg_write, 0);
    check("t3_idle_stall", stall, 0);
    check("t3_idle_rsp_ready", acc_rsp_ready, 0);
    cycle();
    check("t3_error_one_cycle", acc_error, 0);

    // 4: ALU collides with the accelerator WRITE cycle
    dispatch(1'b1, 1'b0, 5'b11000, 3'd1, 19'h00005, 19'h00006);
    acc_req_ready = 1'b1;
    cycle();
    undispatch();
    cycle();
    acc_req_ready = 1'b0;
    acc_rsp_valid = 1'b1;
    acc_rsp_data  = 19'h12345;
    cycle();
    acc_rsp_valid = 1'b0;
    alu_valid     = 1'b1;
    alu_rd        = 3'd5;
    alu_data      = 19'h00077;
    cycle();
    alu_valid     = 1'b0;
    check("t4_alu_write", reg_write, 1);
    check("t4_alu_rd", wb_rd, 5);
    check("t4_alu_data", wb_data, 19'h00077);
    check("t4_still_stalled", stall, 1);
    cycle();
    check("t4_acc_write", reg_write, 1);
    check("t4_acc_rd", wb_rd, 1);
    check("t4_acc_data", wb_data, 19'h12345);
    cycle();
    check("t4_write_done", reg_write, 0);

    // 5: asynchronous reset while in WAIT
    dispatch(1'b0, 1'b1, 5'b11001, 3'd6, 19'h00AAA, 19'h00BBB);
    acc_req_ready = 1'b1;
    cycle();
    undispatch();
    cycle();
    acc_req_ready = 1'b0;
    check("t5_in_wait", acc_rsp_ready, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t5_rst_stall", stall, 0);
    check("t5_rst_rsp_ready", acc_rsp_ready, 0);
    check("t5_rst_acc_op", acc_op, 0);
    check("t5_rst_acc_a", acc_a, 0);
    check("t5_rst_reg_write", reg_write, 0);
    cycle();
    rst = 1'b1;
    acc_rsp_valid = 1'b1;
    acc_rsp_data  = 19'h01111;
    cycle();
    check("t5_no_write_a", reg_write, 0);
    acc_rsp_valid = 1'b0;
    cycle();
    check("t5_no_write_b", reg_write, 0);

    // 6: non-accelerator opcode is ignored
    dispatch(1'b0, 1'b0, 5'b00001, 3'd7, 19'h00123, 19'h00456);
    #1;
    check("t6_no_stall", stall, 0);
    cycle();
    undispatch();
    check("t6_no_req", acc_req_valid, 0);
    check("t6_no_stall_next", stall, 0);

    // ALU writeback while idle, full-scale data
    alu_valid = 1'b1;
    alu_rd    = 3'd7;
    alu_data  = 19'h7FFFF;
    cycle();
    alu_valid = 1'b0;
    check("alu_idle_write", reg_write, 1);
    check("alu_idle_rd", wb_rd, 7);
    check("alu_idle_data", wb_data, 19'h7FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
